// File: rtl/m_dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package m_dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam int DMEM_CNT_W = 4;

    // Low address bits of a word-aligned byte address.
    localparam logic [1:0] ALIGN_OK = 2'b00;

endpackage

// File: rtl/m_dmem_array.sv
// Single-port word RAM: synchronous write, registered read with reset on the read register only.
module m_dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/m_dmem_responder.sv
// MEM-stage data-memory responder: wait-state FSM, request latches, pipeline stall and
// misalignment reporting around a word RAM.
module m_dmem_responder
    import m_dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreqM,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdata,
    output logic        memstall,
    output logic        misaligned,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? '0 : DMEM_CNT_W'(WAIT_CYCLES - 1);

    dmem_state_t           state_q, state_d;
    logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]         idx_q;
    logic [31:0]           wdata_q;
    logic                  write_q;

    logic                  req_ok, req_bad, access;
    logic                  acc_write;
    logic [AW-1:0]         acc_idx;
    logic [31:0]           acc_wdata;
    logic                  unused_addr_bits;

    assign req_ok  = memreqM && (aluoutM[1:0] == ALIGN_OK);
    assign req_bad = memreqM && (aluoutM[1:0] != ALIGN_OK);

    // Upper address bits only select the wrap image, so they are dropped.
    assign unused_addr_bits = ^aluoutM[31:AW+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    if (WAIT_CYCLES == 0) begin
                        access  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    access  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && req_ok) begin
            idx_q   <= aluoutM[AW+1:2];
            wdata_q <= writedataM;
            write_q <= memwriteM;
        end
    end

    // A zero-wait access happens on the accept edge, before the latches hold the request.
    assign acc_idx   = (state_q == IDLE) ? aluoutM[AW+1:2] : idx_q;
    assign acc_wdata = (state_q == IDLE) ? writedataM      : wdata_q;
    assign acc_write = (state_q == IDLE) ? memwriteM       : write_q;

    m_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (access && acc_write && !reset),
        .re    (access && !acc_write && !reset),
        .addr  (acc_idx),
        .wdata (acc_wdata),
        .rdata (readdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned <= 1'b0;
        end else begin
            misaligned <= (state_q == IDLE) && req_bad;
        end
    end

    assign memstall  = !reset && (((state_q == IDLE) && req_ok) || (state_q == WAIT));
    assign dbg_state = state_q;

endmodule

// File: doc/m_dmem_responder.md
# m_dmem_responder

Data-memory responder for the MEM stage of the pipelined core. It accepts load and store requests from the EX/MEM side and returns the load result on `readdata`, which the MEM/WB pipeline register captures. A configurable number of wait states is modelled, and `memstall` freezes the pipeline until each access completes.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; must be a power of two, at least 4.
- `WAIT_CYCLES`, default 2: extra wait states per access; range 0..15.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high reset.
- `memreqM`  in  1: the instruction in MEM performs a memory access.
- `memwriteM`  in  1: 1 = store, 0 = load; valid when `memreqM`=1.
- `aluoutM`  in  32: byte address.
- `writedataM`  in  32: store data.
- `readdata`  out  32: load result, registered; feeds the MEM/WB register.
- `memstall`  out  1: combinational; holds PC, IF/ID, ID/EX, EX/MEM and MEM/WB while an access is pending.
- `misaligned`  out  1: registered one-cycle pulse when a request is rejected for misalignment.

## Operation
- FSM states are IDLE, WAIT and DONE.
- **IDLE**
  - If `memreqM`=1 and `aluoutM[1:0]`=0, latch the address, data and direction ("accept").
    - If `WAIT_CYCLES`=0, perform the access on this edge and go to DONE.
    - Otherwise set `cnt` to `WAIT_CYCLES`-1 and go to WAIT.
  - If `memreqM`=1 and `aluoutM[1:0]`≠0, set `misaligned` to 1 for one cycle. No access occurs, no stall is raised, `readdata` is unchanged and the state stays IDLE.
- **WAIT**
  - If `cnt`≠0, decrement it.
  - If `cnt`=0, perform the access on this edge and go to DONE.
- **Access**
  - Load: `readdata` ← mem[index].
  - Store: mem[index] ← latched data; `readdata` is unchanged.
  - index = address bits [log2(`DEPTH_WORDS`)+1 : 2]. Upper address bits are ignored, so addresses wrap modulo the memory size.
- **DONE**
  - `memstall`=0 and `readdata` is valid, so the pipeline advances at the end of this cycle.
  - Unconditionally return to IDLE. `memreqM` in this cycle belongs to the completing instruction and is ignored.
- **memstall** = (IDLE and `memreqM` and aligned) or WAIT.
- Inputs are held stable by the stall. Changes to `aluoutM`, `writedataM` or `memwriteM` after accept are ignored, because the latched copies are used.
- **Reset**
  - Sets state to IDLE, `cnt` to 0, `readdata` to 0 and `misaligned` to 0.
  - Memory contents are not reset.
  - An access aborted before its access edge is discarded; the store is not committed.

## Timing
- Request present in cycle N (IDLE): `memstall`=1 in cycles N..N+`WAIT_CYCLES`, DONE in cycle N+`WAIT_CYCLES`+1.
- Each access therefore stalls for `WAIT_CYCLES`+1 cycles.
- A back-to-back request is seen in cycle N+`WAIT_CYCLES`+2, when the next instruction reaches MEM and the FSM is back in IDLE. There is no bubble beyond the stall.
- `misaligned` is high in the cycle after the rejected request.
- Reset asserted in any cycle gives IDLE with `memstall`=0 in the following cycle.

## Structure
- Package `m_dmem_pkg`:
  - `dmem_state_t` enum {IDLE, WAIT, DONE}.
  - `DMEM_CNT_W` = 4 (wait counter width).
  - Alignment-check constant.
- Sub-module `m_dmem_array`: single-port word RAM with synchronous write, registered read and `DEPTH_WORDS` parameter, used by the FSM at the access edge.
- Top level: FSM, counter, request latches, stall and misalignment logic.

## Test plan
- **Reset:** hold `reset` for 2 cycles with `memreqM`=1 → `readdata`=0, `memstall`=0, `misaligned`=0, state IDLE.
- **Store then load, `WAIT_CYCLES`=2:** store 0xDEADBEEF to 0x10, then load 0x10.
  - Each access shows `memstall` high for exactly 3 cycles.
  - The load's DONE cycle shows `readdata`=0xDEADBEEF.
- **Back-to-back loads, `WAIT_CYCLES`=0:** preload 0x4=0x11111111 and 0x8=0x22222222, then issue loads on consecutive instructions.
  - Each load stalls 1 cycle.
  - `readdata` shows 0x11111111, then 0x22222222, in the respective DONE cycles.
- **Misaligned load:** load at 0x13 → `misaligned`=1 for one cycle, `memstall` never high, `readdata` unchanged.
- **Reset mid-store, `WAIT_CYCLES`=3:** store 0xCAFEF00D to 0x20 (old value 0x0), then assert `reset` in the 2nd WAIT cycle.
  - `memstall`=0 on the next cycle.
  - A subsequent load of 0x20 returns 0x0.
- **Address wrap, `DEPTH_WORDS`=256:** store 0xA5A5A5A5 to 0x400, then load 0x0 → `readdata`=0xA5A5A5A5.
